// File: rtl/kcpsmx_call_stack.sv
// Call/return stack for the KCPSMX fetch stage: {addr, flags} entries, occupancy and sticky errors.
// Define KCPSMX_STACK_TRAP_EN to drop push-while-full / pop-while-empty; default wraps like KCPSM3.
module kcpsmx_call_stack #(
    parameter int STACK_WIDTH = 10,
    parameter int STACK_DEPTH = 5,
    parameter int FLAG_WIDTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [STACK_WIDTH-1:0] push_addr,
    input  logic [FLAG_WIDTH-1:0]  push_flags,
    input  logic                   clear_err,
    output logic [STACK_WIDTH-1:0] top_addr,
    output logic [FLAG_WIDTH-1:0]  top_flags,
    output logic [STACK_DEPTH:0]   count,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int SIZE = 1 << STACK_DEPTH;
    localparam int EW   = STACK_WIDTH + FLAG_WIDTH;
    localparam logic [STACK_DEPTH:0] SIZE_C = (STACK_DEPTH + 1)'(SIZE);

    logic [EW-1:0]          mem_q [SIZE];
    logic [STACK_DEPTH-1:0] sp_q, sp_d, sp_m1;
    logic [STACK_DEPTH:0]   count_q, count_d;
    logic                   ovf_q, ovf_d, unf_q, unf_d;
    logic                   we;
    logic [STACK_DEPTH-1:0] waddr;
    logic                   empty_w, full_w;
    logic [EW-1:0]          top_entry;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == SIZE_C);
    assign sp_m1   = sp_q - STACK_DEPTH'(1);

    // Occupancy (count_q) is the whole state machine: 0 = empty, SIZE = full, else partial.
    always_comb begin
        sp_d    = sp_q;
        count_d = count_q;
        ovf_d   = ovf_q & ~clear_err;
        unf_d   = unf_q & ~clear_err;
        we      = 1'b0;
        waddr   = sp_q;
        if (push && pop && !empty_w) begin
            we    = 1'b1;
            waddr = sp_m1;
        end else if (push) begin
            if (full_w) begin
                ovf_d = 1'b1;
`ifdef KCPSMX_STACK_TRAP_EN
                we    = 1'b0;
`else
                we    = 1'b1;
                sp_d  = sp_q + STACK_DEPTH'(1);
`endif
            end else begin
                we      = 1'b1;
                sp_d    = sp_q + STACK_DEPTH'(1);
                count_d = count_q + (STACK_DEPTH + 1)'(1);
            end
        end else if (pop) begin
            if (empty_w) begin
                unf_d = 1'b1;
`ifdef KCPSMX_STACK_TRAP_EN
                sp_d  = sp_q;
`else
                sp_d  = sp_m1;
`endif
            end else begin
                sp_d    = sp_m1;
                count_d = count_q - (STACK_DEPTH + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is deliberately not reset; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (we && rst_n) begin
            mem_q[waddr] <= {push_addr, push_flags};
        end
    end

    assign top_entry = mem_q[sp_m1];
    assign top_addr  = empty_w ? '0 : top_entry[EW-1:FLAG_WIDTH];
    assign top_flags = empty_w ? '0 : top_entry[FLAG_WIDTH-1:0];
    assign count     = count_q;
    assign empty     = empty_w;
    assign full      = full_w;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
endmodule

// File: tb/tb_kcpsmx_call_stack.sv
// Self-checking bench for kcpsmx_call_stack: directed plan plus random traffic against a queue model.
module tb_kcpsmx_call_stack;
    localparam int W = 10;
    localparam int D = 5;
    localparam int F = 2;
    localparam int SIZE = 1 << D;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         push = 1'b0, pop = 1'b0, clear_err = 1'b0;
    logic [W-1:0] push_addr = '0;
    logic [F-1:0] push_flags = '0;
    logic [W-1:0] top_addr;
    logic [F-1:0] top_flags;
    logic [D:0]   count;
    logic         empty, full, overflow, underflow;

    kcpsmx_call_stack #(.STACK_WIDTH(W), .STACK_DEPTH(D), .FLAG_WIDTH(F)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
        .push_addr(push_addr), .push_flags(push_flags), .clear_err(clear_err),
        .top_addr(top_addr), .top_flags(top_flags), .count(count),
        .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: bottom of stack at the front of the queue, top at the back.
    int unsigned ma[$];
    int unsigned mf[$];
    bit movf = 0, munf = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = ma.size();
        chk({tag, ".top_addr"},  32'(top_addr),  (n == 0) ? 0 : ma[n-1]);
        chk({tag, ".top_flags"}, 32'(top_flags), (n == 0) ? 0 : mf[n-1]);
        chk({tag, ".count"},     32'(count),     n);
        chk({tag, ".empty"},     32'(empty),     32'(n == 0));
        chk({tag, ".full"},      32'(full),      32'(n == SIZE));
        chk({tag, ".overflow"},  32'(overflow),  32'(movf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(munf));
    endtask

    task automatic model_step(input bit p, input bit q, input int unsigned a,
                              input int unsigned f, input bit ce);
        int n;
        bit sov, sun;
        n = ma.size();
        sov = 0;
        sun = 0;
        if (p && q && n > 0) begin
            ma[n-1] = a;
            mf[n-1] = f;
        end else if (p) begin
            if (n == SIZE) begin
                sov = 1;
`ifndef KCPSMX_STACK_TRAP_EN
                void'(ma.pop_front());
                void'(mf.pop_front());
                ma.push_back(a);
                mf.push_back(f);
`endif
            end else begin
                ma.push_back(a);
                mf.push_back(f);
            end
        end else if (q) begin
            if (n == 0) sun = 1;
            else begin
                void'(ma.pop_back());
                void'(mf.pop_back());
            end
        end
        movf = (movf && !ce) || sov;
        munf = (munf && !ce) || sun;
    endtask

    task automatic op(input string tag, input bit p, input bit q, input int unsigned a,
                      input int unsigned f, input bit ce);
        @(negedge clk);
        push = p; pop = q; clear_err = ce;
        push_addr = a[W-1:0];
        push_flags = f[F-1:0];
        @(posedge clk);
        model_step(p, q, a & 32'h3FF, f & 32'h3, ce);
        #1;
        check_all(tag);
    endtask

    initial begin
        int unsigned exp_a;
        int bias;
        #3;
        check_all("reset");
        @(negedge clk) rst_n = 1'b1;
        op("idle_after_reset", 0, 0, 0, 0, 0);

        op("push123", 1, 0, 'h123, 1, 0);
        op("push3ff", 1, 0, 'h3FF, 2, 0);
        chk("tp1.top_addr", 32'(top_addr), 'h3FF);
        chk("tp1.top_flags", 32'(top_flags), 2);
        chk("tp1.count", 32'(count), 2);
        op("pop1", 0, 1, 0, 0, 0);
        chk("tp1.pop_addr", 32'(top_addr), 'h123);
        chk("tp1.pop_count", 32'(count), 1);
        op("pop2", 0, 1, 0, 0, 0);

        for (int i = 0; i < SIZE; i++) op("fill", 1, 0, i, i % 4, 0);
        chk("fill.full", 32'(full), 1);
        chk("fill.count", 32'(count), SIZE);
        op("push_full", 1, 0, 'h155, 3, 0);
        chk("push_full.overflow", 32'(overflow), 1);
`ifdef KCPSMX_STACK_TRAP_EN
        chk("trap.top_addr", 32'(top_addr), 'h01F);
`else
        chk("wrap.top_addr", 32'(top_addr), 'h155);
        chk("wrap.count", 32'(count), SIZE);
`endif
        for (int i = 0; i < SIZE; i++) begin
`ifdef KCPSMX_STACK_TRAP_EN
            exp_a = 31 - i;
`else
            exp_a = (i == 0) ? 'h155 : 32 - i;
`endif
            chk("drain.lifo", 32'(top_addr), exp_a);
            op("drain", 0, 1, 0, 0, 0);
        end
        chk("drain.empty", 32'(empty), 1);

        op("pop_empty", 0, 1, 0, 0, 0);
        chk("pop_empty.underflow", 32'(underflow), 1);
        op("clear", 0, 0, 0, 0, 1);
        chk("clear.underflow", 32'(underflow), 0);
        op("clear_and_pop", 0, 1, 0, 0, 1);
        chk("clear_and_pop.underflow", 32'(underflow), 1);

        op("p3a", 1, 0, 'h011, 1, 0);
        op("p3b", 1, 0, 'h022, 2, 0);
        op("p3c", 1, 0, 'h033, 3, 0);
        op("replace", 1, 1, 'h2AA, 0, 0);
        chk("replace.count", 32'(count), 3);
        chk("replace.top_addr", 32'(top_addr), 'h2AA);
        op("replace_pop", 0, 1, 0, 0, 0);
        chk("replace.below", 32'(top_addr), 'h022);

        for (int k = 0; k < 2000; k++) begin
            bias = ((k / 200) % 2) ? 75 : 25;
            op("rand", $urandom_range(0, 99) < bias, $urandom_range(0, 99) < (100 - bias),
               $urandom_range(0, 1023), $urandom_range(0, 3), $urandom_range(0, 19) == 0);
        end

        for (int i = 0; i < SIZE + 1 && ma.size() > 0; i++) op("empty_out", 0, 1, 0, 0, 0);
        op("pre_rst_underflow", 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) op("pre_rst_push", 1, 0, 'h040 + i, i % 4, 0);
        chk("pre_rst.count", 32'(count), 5);
        @(negedge clk);
        push = 0; pop = 0; clear_err = 0;
        #2 rst_n = 1'b0;
        #1;
        ma.delete(); mf.delete(); movf = 0; munf = 0;
        check_all("async_reset");
        @(negedge clk) rst_n = 1'b1;
        op("idle_after_reset2", 0, 0, 0, 0, 0);
        op("push0a5", 1, 0, 'h0A5, 1, 0);
        chk("post_rst.top_addr", 32'(top_addr), 'h0A5);
        chk("post_rst.count", 32'(count), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
